// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, default timeout
// and the dmem-streak limit that triggers the imem starvation guard.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam int         TIMEOUT_DEFAULT = 16;
  localparam logic [2:0] STARVE_LIMIT    = 3'd4;

endpackage

// File: rtl/mem_arb_timer.sv
// Grant-cycle counter: start arms it at the grant edge, clear disarms it, and
// expired is high during the TIMEOUT-th cycle of an armed grant.
module mem_arb_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
    end else if (run_q) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of grant cycles already completed.
  assign expired_o = run_q && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter in front of a single shared memory port,
// with dmem priority, an imem starvation guard and a completion timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_req,
  input  logic [31:0] i_imem_addr,
  output logic        o_imem_ready,
  output logic [31:0] o_imem_rdata,
  input  logic        i_dmem_req,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic [31:0] o_dmem_rdata,
  output logic        o_err,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  arb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        wen_q, wen_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        iready_q, iready_d;
  logic        dready_q, dready_d;
  logic        err_q, err_d;
  logic [2:0]  streak_q, streak_d;
  logic        tmr_start, tmr_clear, tmr_expired;
  logic        starve;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (i_clk),
    .rst_i     (i_rst),
    .start_i   (tmr_start),
    .clear_i   (tmr_clear),
    .expired_o (tmr_expired)
  );

  // streak_q counts consecutive dmem grants taken while imem was waiting.
  assign starve = i_imem_req && (streak_q >= STARVE_LIMIT);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    wen_d     = wen_q;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
    iready_d  = 1'b0;
    dready_d  = 1'b0;
    err_d     = 1'b0;
    streak_d  = streak_q;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_dmem_req && !starve) begin
          state_d   = GRANT_D;
          addr_d    = i_dmem_addr;
          wdata_d   = i_dmem_wdata;
          mask_d    = i_dmem_mask;
          wen_d     = i_dmem_wen;
          tmr_start = 1'b1;
          streak_d  = i_imem_req ? streak_q + 3'd1 : 3'd0;
        end else if (i_imem_req) begin
          state_d   = GRANT_I;
          addr_d    = i_imem_addr;
          wdata_d   = '0;
          mask_d    = 4'b1111;
          wen_d     = 1'b0;
          tmr_start = 1'b1;
          streak_d  = 3'd0;
        end
      end
      GRANT_I, GRANT_D: begin
        // A completion in the final allowed cycle still wins over the timeout.
        if (i_mem_valid) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
          if (state_q == GRANT_I) begin
            iready_d = 1'b1;
            irdata_d = i_mem_rdata;
          end else begin
            dready_d = 1'b1;
            if (!wen_q) drdata_d = i_mem_rdata;
          end
        end else if (tmr_expired) begin
          state_d   = IDLE;
          tmr_clear = 1'b1;
          err_d     = 1'b1;
          if (state_q == GRANT_I) iready_d = 1'b1;
          else                    dready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      wen_q    <= 1'b0;
      irdata_q <= '0;
      drdata_q <= '0;
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      wen_q    <= wen_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      iready_q <= iready_d;
      dready_q <= dready_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  assign o_mem_ren    = (state_q != IDLE) && !wen_q;
  assign o_mem_wen    = (state_q != IDLE) && wen_q;
  assign o_mem_addr   = addr_q & 32'hFFFF_FFFC;
  assign o_mem_wdata  = wdata_q;
  assign o_mem_mask   = mask_q;
  assign o_imem_ready = iready_q;
  assign o_imem_rdata = irdata_q;
  assign o_dmem_ready = dready_q;
  assign o_dmem_rdata = drdata_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios pinned with literal values, then randomized traffic.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemReq, dmemReq, dmemWen, memValid;
  logic [31:0] imemAddr, dmemAddr, dmemWdata, memRdata;
  logic [3:0]  dmemMask;
  logic        imemReady, dmemReady, err, memRen, memWen;
  logic [31:0] imemRdata, dmemRdata, memAddr, memWdata;
  logic [3:0]  memMask;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the memory, how long they have waited, and what
  // each output must show during the current cycle.
  int          owner;
  int          age;
  int          streak;
  logic [31:0] mAddr, mWdata;
  logic [3:0]  mMask;
  logic        mWen;
  logic        eIReady, eDReady, eErr;
  logic [31:0] eIRdata, eDRdata;

  mem_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_imem_req   (imemReq),
    .i_imem_addr  (imemAddr),
    .o_imem_ready (imemReady),
    .o_imem_rdata (imemRdata),
    .i_dmem_req   (dmemReq),
    .i_dmem_wen   (dmemWen),
    .i_dmem_addr  (dmemAddr),
    .i_dmem_wdata (dmemWdata),
    .i_dmem_mask  (dmemMask),
    .o_dmem_ready (dmemReady),
    .o_dmem_rdata (dmemRdata),
    .o_err        (err),
    .o_mem_ren    (memRen),
    .o_mem_wen    (memWen),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_mem_mask   (memMask),
    .i_mem_valid  (memValid),
    .i_mem_rdata  (memRdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic modelStep();
    eIReady = 1'b0;
    eDReady = 1'b0;
    eErr    = 1'b0;
    if (rst) begin
      owner   = 0;
      age     = 0;
      streak  = 0;
      eIRdata = '0;
      eDRdata = '0;
      return;
    end
    if (owner == 0) begin
      if (dmemReq && !(imemReq && streak >= 4)) begin
        owner  = 2;
        mAddr  = dmemAddr;
        mWdata = dmemWdata;
        mMask  = dmemMask;
        mWen   = dmemWen;
        streak = imemReq ? streak + 1 : 0;
        age    = 0;
      end else if (imemReq) begin
        owner  = 1;
        mAddr  = imemAddr;
        mMask  = 4'b1111;
        mWen   = 1'b0;
        streak = 0;
        age    = 0;
      end
    end else begin
      age++;
      if (memValid || age == TO) begin
        eErr = !memValid;
        if (owner == 1) begin
          eIReady = 1'b1;
          if (memValid) eIRdata = memRdata;
        end else begin
          eDReady = 1'b1;
          if (memValid && !mWen) eDRdata = memRdata;
        end
        owner = 0;
      end
    end
  endtask

  task automatic checkOutput();
    chk("mem_ren", {31'd0, memRen}, {31'd0, owner != 0 && !mWen});
    chk("mem_wen", {31'd0, memWen}, {31'd0, owner != 0 && mWen});
    if (owner != 0) begin
      chk("mem_addr", memAddr, mAddr & 32'hFFFF_FFFC);
      chk("mem_mask", {28'd0, memMask}, {28'd0, mMask});
      if (mWen) chk("mem_wdata", memWdata, mWdata);
    end
    chk("imem_ready", {31'd0, imemReady}, {31'd0, eIReady});
    chk("dmem_ready", {31'd0, dmemReady}, {31'd0, eDReady});
    chk("err", {31'd0, err}, {31'd0, eErr});
    chk("imem_rdata", imemRdata, eIRdata);
    chk("dmem_rdata", dmemRdata, eDRdata);
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Random masters hold their request until the model's ready, then either
  // issue the next request immediately or go quiet.
  task automatic applyStimulus(input int validPct);
    if (imemReq ? eIReady : 1'b1) begin
      imemReq  = ($urandom_range(0, 99) < (imemReq ? 50 : 30));
      imemAddr = $urandom;
    end
    if (dmemReq ? eDReady : 1'b1) begin
      dmemReq   = ($urandom_range(0, 99) < (dmemReq ? 60 : 35));
      dmemWen   = $urandom_range(0, 1) == 1;
      dmemAddr  = $urandom;
      dmemWdata = $urandom;
      dmemMask  = 4'($urandom_range(0, 15));
    end
    memValid = ($urandom_range(0, 99) < validPct);
    memRdata = $urandom;
    rst      = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    rst = 1'b1; imemReq = 0; dmemReq = 0; dmemWen = 0; memValid = 0;
    imemAddr = '0; dmemAddr = '0; dmemWdata = '0; dmemMask = '0; memRdata = '0;
    owner = 0; age = 0; streak = 0; mAddr = '0; mWdata = '0; mMask = '0; mWen = 0;
    eIReady = 0; eDReady = 0; eErr = 0; eIRdata = '0; eDRdata = '0;
    tick();
    tick();
    chk("reset ren", {31'd0, memRen}, 32'd0);
    chk("reset imem_rdata", imemRdata, 32'd0);

    // Single fetch with one-cycle memory latency.
    rst = 1'b0; imemReq = 1; imemAddr = 32'h0000_1002;
    tick();
    chk("fetch ren", {31'd0, memRen}, 32'd1);
    chk("fetch addr", memAddr, 32'h0000_1000);
    chk("fetch mask", {28'd0, memMask}, 32'hF);
    memValid = 1; memRdata = 32'hDEAD_BEEF;
    tick();
    chk("fetch ready", {31'd0, imemReady}, 32'd1);
    chk("fetch rdata", imemRdata, 32'hDEAD_BEEF);
    imemReq = 0; memValid = 0;

    // Simultaneous requests: data first, fetch in the data ready cycle.
    imemReq = 1; imemAddr = 32'h0000_4000;
    dmemReq = 1; dmemWen = 0; dmemAddr = 32'h0000_2000; dmemMask = 4'hF;
    tick();
    chk("both addr", memAddr, 32'h0000_2000);
    memValid = 1; memRdata = 32'h1111_2222;
    tick();
    chk("both dready", {31'd0, dmemReady}, 32'd1);
    chk("both gap ren", {31'd0, memRen}, 32'd0);
    chk("both drdata", dmemRdata, 32'h1111_2222);
    dmemReq = 0; memValid = 0;
    tick();
    chk("both fetch addr", memAddr, 32'h0000_4000);
    memValid = 1; memRdata = 32'h3333_4444;
    tick();
    chk("both iready", {31'd0, imemReady}, 32'd1);
    imemReq = 0; memValid = 0;

    // Store leaves the load data register untouched.
    dmemReq = 1; dmemWen = 1; dmemAddr = 32'h0000_3004;
    dmemWdata = 32'h0000_AB00; dmemMask = 4'b0010;
    tick();
    chk("store wen", {31'd0, memWen}, 32'd1);
    chk("store ren", {31'd0, memRen}, 32'd0);
    chk("store addr", memAddr, 32'h0000_3004);
    memValid = 1; memRdata = 32'hFFFF_0000;
    tick();
    chk("store dready", {31'd0, dmemReady}, 32'd1);
    chk("store drdata", dmemRdata, 32'h1111_2222);
    dmemReq = 0; dmemWen = 0; memValid = 0;

    // Silent memory: strobes stay up TO cycles, then an error completion.
    imemReq = 1; imemAddr = 32'h0000_5000;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("timeout last ren", {31'd0, memRen}, 32'd1);
    tick();
    chk("timeout ren", {31'd0, memRen}, 32'd0);
    chk("timeout iready", {31'd0, imemReady}, 32'd1);
    chk("timeout err", {31'd0, err}, 32'd1);
    chk("timeout irdata", imemRdata, 32'h3333_4444);
    imemReq = 0;

    // Starvation guard: fetch wins after the fourth consecutive data grant.
    dmemReq = 1; dmemWen = 0; dmemAddr = 32'h0000_6000; dmemMask = 4'hF;
    imemReq = 1; imemAddr = 32'h0000_7000; memValid = 1; memRdata = 32'h0;
    for (int i = 0; i < 8; i++) tick();
    chk("starve 4th dready", {31'd0, dmemReady}, 32'd1);
    tick();
    chk("starve fetch addr", memAddr, 32'h0000_7000);
    chk("starve fetch ren", {31'd0, memRen}, 32'd1);
    tick();
    imemReq = 0;
    tick();
    chk("starve 5th addr", memAddr, 32'h0000_6000);
    tick();
    dmemReq = 0; memValid = 0;

    // Reset in the middle of a data grant, with a fetch held through reset.
    dmemReq = 1; dmemAddr = 32'h0000_8000;
    tick();
    tick();
    rst = 1; dmemReq = 0; imemReq = 1; imemAddr = 32'h0000_9000;
    tick();
    chk("rst ren", {31'd0, memRen}, 32'd0);
    chk("rst dready", {31'd0, dmemReady}, 32'd0);
    chk("rst drdata", dmemRdata, 32'd0);
    tick();
    rst = 0;
    tick();
    chk("post-rst grant", memAddr, 32'h0000_9000);
    memValid = 1;
    tick();
    imemReq = 0; memValid = 0;
    tick();

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(45);
      tick();
    end
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(4);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles waiting for i_mem_valid before the transaction is aborted.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_imem_req  input  1  fetch request; held with i_imem_addr until o_imem_ready.
REQ-005 SHALL have port i_imem_addr  input  32  fetch byte address.
REQ-006 SHALL have port o_imem_ready  output  1  one-cycle pulse: fetch done, o_imem_rdata valid.
REQ-007 SHALL have port o_imem_rdata  output  32  fetched word, registered.
REQ-008 SHALL have port i_dmem_req  input  1  data request; held with all i_dmem_* until o_dmem_ready.
REQ-009 SHALL have port i_dmem_wen  input  1  1 = store, 0 = load.
REQ-010 SHALL have port i_dmem_addr  input  32  data byte address.
REQ-011 SHALL have port i_dmem_wdata  input  32  store data, already lane-shifted.
REQ-012 SHALL have port i_dmem_mask  input  4  byte-lane mask.
REQ-013 SHALL have port o_dmem_ready  output  1  one-cycle pulse: data access done.
REQ-014 SHALL have port o_dmem_rdata  output  32  load word, registered.
REQ-015 SHALL have port o_err  output  1  asserted with the ready pulse when the access timed out.
REQ-016 SHALL have port o_mem_ren  output  1  read strobe to the shared memory.
REQ-017 SHALL have port o_mem_wen  output  1  write strobe; never asserted together with o_mem_ren.
REQ-018 SHALL have port o_mem_addr  output  32  word-aligned address; bits [1:0] forced to 0.
REQ-019 SHALL have port o_mem_wdata  output  32  write data.
REQ-020 SHALL have port o_mem_mask  output  4  lane mask; 4'b1111 for fetches.
REQ-021 SHALL have port i_mem_valid  input  1  memory completion; one cycle per access.
REQ-022 SHALL have port i_mem_rdata  input  32  read data, valid while i_mem_valid.

Function
REQ-023 SHALL implement FSM states IDLE, GRANT_I, GRANT_D; reset state IDLE.
REQ-024 IDLE: dmem_req -> GRANT_D; else imem_req -> GRANT_I; else stay. Simultaneous requests: dmem wins.
REQ-025 On the grant edge, SHALL latch address, wdata, mask and wen into registers; o_mem_* are driven only from these registers.
REQ-026 In GRANT_*: o_mem_ren = ~wen (fetch: 1), o_mem_wen = wen; held constant until i_mem_valid or timeout.
REQ-027 i_mem_valid in GRANT_*: capture i_mem_rdata into the requester's rdata register, pulse its ready (o_err=0) on the next cycle, return to IDLE.
REQ-028 Minimum latency: req seen at edge N, strobes high in cycle N+1; if i_mem_valid is high in that cycle, ready pulses in cycle N+2.
REQ-029 SHALL count GRANT_* cycles; when the count reaches TIMEOUT with no i_mem_valid, SHALL drop the strobes, pulse ready with o_err=1, leave rdata unchanged, return to IDLE.
REQ-030 i_mem_valid in IDLE SHALL be ignored; at most one outstanding access.
REQ-031 The ready cycle is spent in IDLE with strobes low; an arbitration decision may be taken in that same cycle (back-to-back, no bubble).
REQ-032 Starvation guard: after 4 consecutive dmem grants with imem_req pending, the next IDLE decision SHALL grant imem.
REQ-033 Store completion SHALL leave o_dmem_rdata unchanged.

Reset
REQ-034 i_rst SHALL force state IDLE, counters 0, all strobes/ready/o_err 0 and rdata registers 0 on the next edge, aborting any in-flight access without a ready pulse.
REQ-035 Requests present during reset SHALL be arbitrated from the first cycle after reset deassertion.

Structure
REQ-036 FSM state encodings and the TIMEOUT default SHALL live in shared package mem_arb_pkg.
REQ-037 Timeout counter SHALL be sub-module mem_arb_timer (start, clear, expired); everything else is flat.

Verification
REQ-038 imem_req addr 0x1002, mem valid after 1 cycle with 0xDEADBEEF -> o_mem_addr 0x1000, mask 1111, imem_ready at N+2, rdata 0xDEADBEEF.
REQ-039 imem and dmem (load 0x2000) requests in the same cycle -> dmem granted first; imem granted in the ready cycle; no overlap of strobes.
REQ-040 Store 0x3004 wdata 0x0000AB00 mask 0010 -> o_mem_wen=1, ren=0, dmem_ready pulse, o_dmem_rdata unchanged.
REQ-041 Memory silent for 16 cycles -> strobes drop, ready pulse with o_err=1, FSM back to IDLE.
REQ-042 5 back-to-back dmem requests with imem pending -> imem granted after the 4th dmem completion.
REQ-043 i_rst asserted mid-GRANT_D -> no ready pulse, all outputs 0 next cycle, FSM IDLE.
